// File: rtl/ex_div_if.sv
// rtl/ex_div_if.sv - EX-stage divider request/result bundle
// Ports (signals):
//   signed_div_i  1        1 = signed divide, 0 = unsigned
//   opdata1_i     WIDTH    dividend
//   opdata2_i     WIDTH    divisor
//   start_i       1        request, held until ready_o is seen
//   annul_i       1        cancel in-flight divide
//   result_o      2*WIDTH  {remainder, quotient}
//   ready_o       1        result_o valid
// Modports: master = EX stage (drives request), slave = divider.
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle restoring divider for the EX stage
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-low reset
//   bus  ex_div_if.slave: operands, start/annul request, {rem, quo} result, ready
// One quotient bit is produced per clock; signed divides run on magnitudes
// and the signs are applied on the final step.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_BYZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t             state_q, state_n;
    logic [CW-1:0]      cnt_q, cnt_n;
    logic [WIDTH-1:0]   quo_q, quo_n;
    logic [WIDTH-1:0]   rem_q, rem_n;
    logic [WIDTH-1:0]   divisor_q, divisor_n;
    logic               sdiv_q, sdiv_n;
    logic               sign1_q, sign1_n;
    logic               sign2_q, sign2_n;
    logic [2*WIDTH-1:0] result_q, result_n;
    logic               ready_q, ready_n;

    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic               step_ok;
    logic [WIDTH-1:0]   step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   fix_rem;
    logic [WIDTH-1:0]   fix_quo;
    logic [WIDTH-1:0]   abs1;
    logic [WIDTH-1:0]   abs2;

    // One restoring step. The shifted partial remainder needs WIDTH+1 bits
    // (it can reach 2*divisor-1), and the trial subtraction one more for the
    // borrow. Whichever branch is taken, the new remainder is below the
    // divisor and therefore fits back into WIDTH bits.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = {1'b0, shifted} - {2'b00, divisor_q};
        step_ok  = ~diff[WIDTH+1];
        step_rem = step_ok ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        step_quo = {quo_q[WIDTH-2:0], step_ok};
        fix_quo  = (sdiv_q && (sign1_q != sign2_q)) ? (WIDTH'(0) - step_quo) : step_quo;
        fix_rem  = (sdiv_q && sign1_q) ? (WIDTH'(0) - step_rem) : step_rem;
        // Magnitude of the most negative value wraps to itself, which is the
        // correct unsigned magnitude.
        abs1     = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ?
                   (WIDTH'(0) - bus.opdata1_i) : bus.opdata1_i;
        abs2     = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ?
                   (WIDTH'(0) - bus.opdata2_i) : bus.opdata2_i;
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        quo_n     = quo_q;
        rem_n     = rem_q;
        divisor_n = divisor_q;
        sdiv_n    = sdiv_q;
        sign1_n   = sign1_q;
        sign2_n   = sign2_q;
        result_n  = result_q;
        ready_n   = ready_q;

        case (state_q)
            ST_FREE: begin
                result_n = '0;
                ready_n  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_n = ST_BYZERO;
                    end else begin
                        state_n   = ST_ON;
                        cnt_n     = '0;
                        quo_n     = abs1;
                        rem_n     = '0;
                        divisor_n = abs2;
                        sdiv_n    = bus.signed_div_i;
                        sign1_n   = bus.opdata1_i[WIDTH-1];
                        sign2_n   = bus.opdata2_i[WIDTH-1];
                    end
                end
            end
            ST_BYZERO: begin
                if (bus.annul_i) begin
                    state_n = ST_FREE;
                end else begin
                    state_n  = ST_END;
                    result_n = '0;
                    ready_n  = 1'b1;
                end
            end
            ST_ON: begin
                if (bus.annul_i) begin
                    state_n  = ST_FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end else begin
                    quo_n = step_quo;
                    rem_n = step_rem;
                    cnt_n = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_n  = ST_END;
                        result_n = {fix_rem, fix_quo};
                        ready_n  = 1'b1;
                    end
                end
            end
            ST_END: begin
                // Annul is deliberately ignored here: the result is complete
                // and EX releases it by dropping start_i.
                if (!bus.start_i) begin
                    state_n  = ST_FREE;
                    result_n = '0;
                    ready_n  = 1'b0;
                end
            end
            default: begin
                state_n  = ST_FREE;
                result_n = '0;
                ready_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_FREE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            sdiv_q    <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            quo_q     <= quo_n;
            rem_q     <= rem_n;
            divisor_q <= divisor_n;
            sdiv_q    <= sdiv_n;
            sign1_q   <= sign1_n;
            sign2_q   <= sign2_n;
            result_q  <= result_n;
            ready_q   <= ready_n;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule
